// File: rtl/vproc_cache_arbiter.sv
// ---------------------------------------------------------------------------
// vproc_cache_arbiter
//
// Shares the CPU-side interface of vproc_cache between the instruction-fetch
// port (port 0) and the vector/scalar load-store port (port 1). One request
// is selected per cycle. The selection is held until the cache grants it. The
// ID of every granted request goes into an in-order FIFO, which routes each
// cache response back to the port that issued it.
//
// Configuration macro:
//   VPROC_CACHE_ARB_RR_EN  defined     -> round-robin on contention
//                          not defined -> fixed priority, port 1 always wins
//
// Parameters:
//   ADDR_BIT_W       address width in bits
//   CPU_BYTE_W       data width in bytes
//   MAX_OUTSTANDING  ID FIFO depth (power of two, >= 1)
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   port_req_i[1:0]       request per port
//   port_addr_i[1:0]      address per port
//   port_we_i[1:0]        write enable per port
//   port_be_i[1:0]        byte enables per port
//   port_wdata_i[1:0]     write data per port
//   port_gnt_o[1:0]       grant per port (combinational from cache_gnt_i)
//   port_rvalid_o[1:0]    response valid per port (combinational from cache_rvalid_i)
//   port_rdata_o          response data shared by both ports
//   port_err_o            response error shared by both ports
//   cache_req_o .. cache_wdata_o      request towards the cache
//   cache_gnt_i .. cache_err_i        grant and response from the cache
// ---------------------------------------------------------------------------
module vproc_cache_arbiter #(
    parameter int ADDR_BIT_W      = 16,
    parameter int CPU_BYTE_W      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,

    input  logic [1:0]                          port_req_i,
    input  logic [1:0][ADDR_BIT_W-1:0]          port_addr_i,
    input  logic [1:0]                          port_we_i,
    input  logic [1:0][CPU_BYTE_W-1:0]          port_be_i,
    input  logic [1:0][CPU_BYTE_W*8-1:0]        port_wdata_i,
    output logic [1:0]                          port_gnt_o,
    output logic [1:0]                          port_rvalid_o,
    output logic [CPU_BYTE_W*8-1:0]             port_rdata_o,
    output logic                                port_err_o,

    output logic                                cache_req_o,
    output logic [ADDR_BIT_W-1:0]               cache_addr_o,
    output logic                                cache_we_o,
    output logic [CPU_BYTE_W-1:0]               cache_be_o,
    output logic [CPU_BYTE_W*8-1:0]             cache_wdata_o,
    input  logic                                cache_gnt_i,
    input  logic                                cache_rvalid_i,
    input  logic [CPU_BYTE_W*8-1:0]             cache_rdata_i,
    input  logic                                cache_err_i
);

    // A depth of one still needs a one-bit pointer; it simply never moves.
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

`ifdef VPROC_CACHE_ARB_RR_EN
    localparam logic PRIO_RST = 1'b0;
`else
    localparam logic PRIO_RST = 1'b1;
`endif

    // Advance a FIFO pointer, wrapping after the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             lock_r;
    logic             lock_id_r;
    logic             prio_r;
    logic             fifo_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic sel_s;
    logic full_s;
    logic empty_s;
    logic cache_req_s;
    logic accept_s;
    logic pop_s;
    logic head_s;

    // Port selection: a stalled request keeps the lock; otherwise the single
    // requester wins, and on contention the favoured port wins.
    always_comb begin
        sel_s = 1'b0;
        if (lock_r) begin
            sel_s = lock_id_r;
        end else begin
            case (port_req_i)
                2'b01:   sel_s = 1'b0;
                2'b10:   sel_s = 1'b1;
                2'b11:   sel_s = prio_r;
                default: sel_s = prio_r;
            endcase
        end
    end

    // FIFO status, request qualification and handshake events. Full is taken
    // from the registered count only, so a response in the same cycle cannot
    // reach the request path combinationally.
    always_comb begin
        full_s      = (count_r == CNT_FULL);
        empty_s     = (count_r == {CNT_W{1'b0}});
        cache_req_s = port_req_i[sel_s] & ~full_s;
        accept_s    = cache_req_s & cache_gnt_i;
        pop_s       = cache_rvalid_i & ~empty_s;
        head_s      = fifo_r[rd_ptr_r];
    end

    // Output drive: everything is forced low while reset is held.
    always_comb begin
        cache_req_o   = 1'b0;
        cache_addr_o  = {ADDR_BIT_W{1'b0}};
        cache_we_o    = 1'b0;
        cache_be_o    = {CPU_BYTE_W{1'b0}};
        cache_wdata_o = {(CPU_BYTE_W*8){1'b0}};
        port_gnt_o    = 2'b00;
        port_rvalid_o = 2'b00;
        port_rdata_o  = {(CPU_BYTE_W*8){1'b0}};
        port_err_o    = 1'b0;
        if (rst_i) begin
            port_gnt_o    = 2'b00;
        end else begin
            cache_req_o           = cache_req_s;
            cache_addr_o          = port_addr_i[sel_s];
            cache_we_o            = port_we_i[sel_s];
            cache_be_o            = port_be_i[sel_s];
            cache_wdata_o         = port_wdata_i[sel_s];
            port_gnt_o[sel_s]     = accept_s;
            // A response with nothing outstanding has no owner and is dropped.
            port_rvalid_o[head_s] = pop_s;
            port_rdata_o          = cache_rdata_i;
            port_err_o            = cache_err_i;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Lock register: pins the selection to a port whose request the cache
    // has not yet granted, so the presented fields stay stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_r    <= 1'b0;
            lock_id_r <= 1'b0;
        end else if (accept_s) begin
            lock_r    <= 1'b0;
            lock_id_r <= lock_id_r;
        end else if (cache_req_s) begin
            lock_r    <= 1'b1;
            lock_id_r <= sel_s;
        end else begin
            lock_r    <= lock_r;
            lock_id_r <= lock_id_r;
        end
    end

    // Contention priority: toggles away from the granted port in round-robin
    // mode, pinned to the load-store port in fixed-priority mode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_r <= PRIO_RST;
        end else begin
`ifdef VPROC_CACHE_ARB_RR_EN
            if (accept_s) begin
                prio_r <= ~sel_s;
            end else begin
                prio_r <= prio_r;
            end
`else
            prio_r <= 1'b1;
`endif
        end
    end

    // ID FIFO storage: records the owner of every granted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_r[i] <= 1'b0;
            end
        end else if (accept_s) begin
            fifo_r[wr_ptr_r] <= sel_s;
        end else begin
            fifo_r[wr_ptr_r] <= fifo_r[wr_ptr_r];
        end
    end

    // ID FIFO pointers and occupancy; a push and a pop in the same cycle
    // leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_vproc_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vproc_cache_arbiter
//
// Self-checking bench for vproc_cache_arbiter. The bench plays the cache.
// Each grant it expects pushes the owning port, data and error flag of the
// response it will later return into a scoreboard queue. Each response it
// returns pops that queue and compares the port routing and data.
// Arbitration expectations follow VPROC_CACHE_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_vproc_cache_arbiter;

    localparam int AW = 16;
    localparam int BW = 4;
    localparam int DW = BW * 8;

`ifdef VPROC_CACHE_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]    port;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic                clk;
    logic                rst;
    logic [1:0]          req;
    logic [1:0][AW-1:0]  paddr;
    logic [1:0]          pwe;
    logic [1:0][BW-1:0]  pbe;
    logic [1:0][DW-1:0]  pwdata;
    logic [1:0]          port_gnt;
    logic [1:0]          port_rvalid;
    logic [DW-1:0]       port_rdata;
    logic                port_err;
    logic                cache_req;
    logic [AW-1:0]       cache_addr;
    logic                cache_we;
    logic [BW-1:0]       cache_be;
    logic [DW-1:0]       cache_wdata;
    logic                cgnt;
    logic                crvalid;
    logic [DW-1:0]       crdata;
    logic                cerr;

    rsp_t          sb [$];
    logic [DW-1:0] next_data;
    int            n_checks;
    int            n_errors;

    vproc_cache_arbiter #(
        .ADDR_BIT_W      (AW),
        .CPU_BYTE_W      (BW),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .port_req_i     (req),
        .port_addr_i    (paddr),
        .port_we_i      (pwe),
        .port_be_i      (pbe),
        .port_wdata_i   (pwdata),
        .port_gnt_o     (port_gnt),
        .port_rvalid_o  (port_rvalid),
        .port_rdata_o   (port_rdata),
        .port_err_o     (port_err),
        .cache_req_o    (cache_req),
        .cache_addr_o   (cache_addr),
        .cache_we_o     (cache_we),
        .cache_be_o     (cache_be),
        .cache_wdata_o  (cache_wdata),
        .cache_gnt_i    (cgnt),
        .cache_rvalid_i (crvalid),
        .cache_rdata_i  (crdata),
        .cache_err_i    (cerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Hold reset for n cycles with busy inputs; every output must stay 0.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst     = 1'b1;
            req     = 2'b11;
            cgnt    = 1'b1;
            crvalid = 1'b1;
            crdata  = 32'hFFFF_FFFF;
            cerr    = 1'b1;
            @(negedge clk);
            check_val("reset_outputs",
                      128'({cache_req, cache_addr, cache_we, cache_be, cache_wdata,
                            port_gnt, port_rvalid, port_rdata, port_err}),
                      128'd0);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        req     = 2'b00;
        cgnt    = 1'b0;
        crvalid = 1'b0;
        cerr    = 1'b0;
        sb.delete();
    endtask

    // One clock cycle of stimulus and checking.
    //   r, g, rv : port requests, cache grant, cache rvalid driven this cycle
    //   exp_gnt  : expected port_gnt_o; a non-zero value schedules a response
    //   exp_creq : expected cache_req_o
    //   exp_sel  : port whose fields must appear on the cache side (-1: none)
    task automatic do_cycle(input logic [1:0] r, input logic g, input logic rv,
                            input logic [1:0] exp_gnt, input logic exp_creq,
                            input int exp_sel);
        rsp_t ent;
        bit   have;
        logic s;
        req     = r;
        cgnt    = g;
        crvalid = rv;
        have    = rv && (sb.size() > 0);
        ent     = '0;
        if (have) begin
            ent    = sb[0];
            crdata = ent.data;
            cerr   = ent.err;
        end else begin
            crdata = 32'h5A5A_5A5A;
            cerr   = 1'b0;
        end
        @(negedge clk);
        check_val("cache_req", 128'(cache_req), 128'(exp_creq));
        check_val("port_gnt", 128'(port_gnt), 128'(exp_gnt));
        if (exp_sel >= 0) begin
            s = exp_sel[0];
            check_val("cache_fields",
                      128'({cache_addr, cache_we, cache_be, cache_wdata}),
                      128'({paddr[s], pwe[s], pbe[s], pwdata[s]}));
        end
        if (exp_gnt != 2'b00) begin
            sb.push_back('{port: exp_gnt, data: next_data, err: next_data[0]});
            next_data = next_data + 32'h11;
        end
        if (have) begin
            void'(sb.pop_front());
            check_val("rsp_route", 128'(port_rvalid), 128'(ent.port));
            check_val("rsp_data", 128'({port_rdata, port_err}), 128'({ent.data, ent.err}));
        end else begin
            check_val("no_rvalid", 128'(port_rvalid), 128'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_p;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req       = 2'b00;
        cgnt      = 1'b0;
        crvalid   = 1'b0;
        crdata    = 32'h0;
        cerr      = 1'b0;
        paddr[0]  = 16'h0040;
        paddr[1]  = 16'h0B00;
        pwe       = 2'b10;
        pbe[0]    = 4'hF;
        pbe[1]    = 4'h3;
        pwdata[0] = 32'hA0A0_A0A0;
        pwdata[1] = 32'hB1B1_B1B1;
        next_data = 32'h0000_0011;

        do_reset(3);

        // Single port 0 read, immediate grant, response one cycle later.
        next_data = 32'hDEAD_BEEF;
        do_cycle(2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 0);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);

        // Continuous contention with an always-granting cache.
        do_reset(1);
        next_data = 32'h0000_1000;
        for (int i = 0; i < 4; i++) begin
            exp_p = RR_EN ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b10;
            do_cycle(2'b11, 1'b1, (i > 0), exp_p, 1'b1, (exp_p == 2'b01) ? 0 : 1);
        end
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);

        // Stall lock: port 0 misses for 3 cycles while port 1 joins.
        do_reset(1);
        do_cycle(2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 0);
        do_cycle(2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 0);
        do_cycle(2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 0);
        do_cycle(2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 0);
        do_cycle(2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);

        // Full FIFO blocks requests; a same-cycle pop does not unblock.
        do_cycle(2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 0);
        do_cycle(2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 0);
        do_cycle(2'b01, 1'b1, 1'b0, 2'b00, 1'b0, -1);
        do_cycle(2'b01, 1'b1, 1'b1, 2'b00, 1'b0, -1);
        do_cycle(2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 0);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);

        // Ordering 1 then 0 with data 0x11/0x22, then a spurious rvalid.
        next_data = 32'h0000_0011;
        do_cycle(2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1);
        do_cycle(2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 0);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);
        do_cycle(2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 0);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);

        // Reset with two requests outstanding; late response must be dropped.
        do_cycle(2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 0);
        do_cycle(2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1);
        do_reset(2);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);
        exp_p = RR_EN ? 2'b01 : 2'b10;
        do_cycle(2'b11, 1'b1, 1'b0, exp_p, 1'b1, (exp_p == 2'b01) ? 0 : 1);
        do_cycle(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);

        check_val("sb_drained", 128'(sb.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
